bw_io_rcvr_sync_filt: RTL and testbench

Receiver-side conditioning stage that consumes the `torcvr` output of the pad input filter and delivers a clean, core-clock-domain level to core logic. The raw pad level is asynchronous to `clk`, so the block:
- synchronizes it through a flop chain;
- rejects pulses shorter than a programmable number of cycles with a counter-based debounce state machine;
- emits single-cycle rise and fall event pulses.

---
 rtl/bw_io_rcvr_pkg.sv | 21 ++
 rtl/bw_io_rcvr_sync.sv | 25 ++
 rtl/bw_io_rcvr_sync_filt.sv | 154 +++++++++++++++
 tb/tb_bw_io_rcvr_sync_filt.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_io_rcvr_pkg.sv
// Shared types and constants for the pad receiver conditioning path.
// Optional glitch counter is enabled with macro BW_IO_RCVR_GLITCH_CNT_EN.
package bw_io_rcvr_pkg;

   localparam int unsigned RCVR_CNT_W    = 4;
   localparam int unsigned RCVR_GLITCH_W = 8;
   localparam logic [RCVR_GLITCH_W-1:0] RCVR_GLITCH_MAX = 8'hFF;

   typedef enum logic [1:0] {
      LO      = 2'd0,
      LO_PEND = 2'd1,
      HI      = 2'd2,
      HI_PEND = 2'd3
   } rcvr_state_t;

   // Filtered level implied by a debounce state.
   function automatic logic rcvr_is_hi(input rcvr_state_t s);
      return (s == HI) || (s == HI_PEND);
   endfunction

endpackage

// File: rtl/bw_io_rcvr_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit level.
// Reusable by any pad receiver; all flops reset to 0.
module bw_io_rcvr_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_l,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   // Shift the raw level through the flop chain.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
      end
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/bw_io_rcvr_sync_filt.sv
// Receiver conditioning: synchronize torcvr, debounce it with a
// counter-based FSM, and emit registered rise/fall event pulses.
// Macro BW_IO_RCVR_GLITCH_CNT_EN adds glitch_clr / glitch_cnt.
module bw_io_rcvr_sync_filt
   import bw_io_rcvr_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYC    = 4
) (
   input  logic                     clk,
   input  logic                     rst_l,
   input  logic                     torcvr,
   input  logic                     filt_en,
`ifdef BW_IO_RCVR_GLITCH_CNT_EN
   input  logic                     glitch_clr,
   output logic [RCVR_GLITCH_W-1:0] glitch_cnt,
`endif
   output logic                     rcvr_out,
   output logic                     rise_pls,
   output logic                     fall_pls
);

   localparam logic [RCVR_CNT_W-1:0] FILT_LIM = RCVR_CNT_W'(FILT_CYC);
   localparam logic [RCVR_CNT_W-1:0] CNT_ONE  = RCVR_CNT_W'(1);

   logic                  sync_q;
   rcvr_state_t           state;
   rcvr_state_t           state_nxt;
   logic [RCVR_CNT_W-1:0] cnt;
   logic [RCVR_CNT_W-1:0] cnt_nxt;
   logic [RCVR_CNT_W-1:0] cnt_inc;
   logic                  hi_c;

   bw_io_rcvr_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_l (rst_l),
      .d     (torcvr),
      .q     (sync_q)
   );

   assign cnt_inc = cnt + CNT_ONE;

   // Debounce state and consecutive-sample counter.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state <= LO;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: bypass forces the settled level; otherwise count stable samples.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!filt_en) begin
         state_nxt = sync_q ? HI : LO;
         cnt_nxt   = '0;
      end else begin
         unique case (state)
            LO: begin
               if (sync_q) begin
                  if (FILT_LIM == CNT_ONE) begin
                     state_nxt = HI;
                  end else begin
                     state_nxt = LO_PEND;
                     cnt_nxt   = CNT_ONE;
                  end
               end
            end
            LO_PEND: begin
               if (!sync_q) begin
                  state_nxt = LO;
                  cnt_nxt   = '0;
               end else if (cnt_inc == FILT_LIM) begin
                  state_nxt = HI;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            HI: begin
               if (!sync_q) begin
                  if (FILT_LIM == CNT_ONE) begin
                     state_nxt = LO;
                  end else begin
                     state_nxt = HI_PEND;
                     cnt_nxt   = CNT_ONE;
                  end
               end
            end
            HI_PEND: begin
               if (sync_q) begin
                  state_nxt = HI;
                  cnt_nxt   = '0;
               end else if (cnt_inc == FILT_LIM) begin
                  state_nxt = LO;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            default: begin
               state_nxt = LO;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Level presented by the current state.
   always_comb begin
      hi_c = rcvr_is_hi(state);
   end

   // Registered level and single-cycle edge events.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rcvr_out <= 1'b0;
         rise_pls <= 1'b0;
         fall_pls <= 1'b0;
      end else begin
         rcvr_out <= hi_c;
         rise_pls <= hi_c & ~rcvr_out;
         fall_pls <= ~hi_c & rcvr_out;
      end
   end

`ifdef BW_IO_RCVR_GLITCH_CNT_EN
   logic abort_c;

   // A pending change that reverts while filtering is a rejected glitch.
   always_comb begin
      abort_c = filt_en & (((state == LO_PEND) & ~sync_q) |
                           ((state == HI_PEND) &  sync_q));
   end

   // Saturating glitch counter; clear has priority over increment.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         glitch_cnt <= '0;
      end else if (glitch_clr) begin
         glitch_cnt <= '0;
      end else if (abort_c && (glitch_cnt != RCVR_GLITCH_MAX)) begin
         glitch_cnt <= glitch_cnt + RCVR_GLITCH_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_bw_io_rcvr_sync_filt.sv
// Self-checking bench for bw_io_rcvr_sync_filt: a default instance and a
// FILT_CYC=1 / SYNC_STAGES=3 instance, each checked against a run-length
// reference whose per-edge expectations are queued when stimulus is applied.
module tb_bw_io_rcvr_sync_filt;

   typedef struct packed {
      logic       out;
      logic       rise;
      logic       fall;
      logic [7:0] gc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_l;
   logic torcvr;
   logic torcvr_f;
   logic filt_en;
   logic clr_v;
   logic rcvr_out, rise_pls, fall_pls;
   logic rcvr_out_f, rise_pls_f, fall_pls_f;
`ifdef BW_IO_RCVR_GLITCH_CNT_EN
   logic [7:0] glitch_cnt, glitch_cnt_f;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   exp_t q0[$];
   exp_t q1[$];

   // Reference state per instance: sync pipe, accepted level, registered
   // output, run length of differing samples, glitch count.
   logic [3:0] ms [2];
   logic       ml [2];
   logic       mo [2];
   int         mr [2];
   int         mg [2];

   always #5 clk = ~clk;

   bw_io_rcvr_sync_filt dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .torcvr     (torcvr),
      .filt_en    (filt_en),
`ifdef BW_IO_RCVR_GLITCH_CNT_EN
      .glitch_clr (clr_v),
      .glitch_cnt (glitch_cnt),
`endif
      .rcvr_out   (rcvr_out),
      .rise_pls   (rise_pls),
      .fall_pls   (fall_pls)
   );

   bw_io_rcvr_sync_filt #(
      .SYNC_STAGES (3),
      .FILT_CYC    (1)
   ) dut_f (
      .clk        (clk),
      .rst_l      (rst_l),
      .torcvr     (torcvr_f),
      .filt_en    (filt_en),
`ifdef BW_IO_RCVR_GLITCH_CNT_EN
      .glitch_clr (clr_v),
      .glitch_cnt (glitch_cnt_f),
`endif
      .rcvr_out   (rcvr_out_f),
      .rise_pls   (rise_pls_f),
      .fall_pls   (fall_pls_f)
   );

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         ms[i] = '0; ml[i] = 1'b0; mo[i] = 1'b0; mr[i] = 0; mg[i] = 0;
      end
   endtask

   // Advance the reference by one clock edge and queue what the DUT must show.
   task automatic model_edge(input int id, input logic t, input logic fe, input logic clr);
      exp_t e;
      logic sq, abort;
      int   s, f;
      s = (id == 0) ? 2 : 3;
      f = (id == 0) ? 4 : 1;
      sq = ms[id][s-1];
      e.out  = ml[id];
      e.rise = ml[id] & ~mo[id];
      e.fall = ~ml[id] & mo[id];
      mo[id] = ml[id];
      abort = fe && (mr[id] > 0) && (sq == ml[id]);
      if (!fe) begin
         ml[id] = sq; mr[id] = 0;
      end else if (sq != ml[id]) begin
         mr[id]++;
         if (mr[id] == f) begin
            ml[id] = sq; mr[id] = 0;
         end
      end else begin
         mr[id] = 0;
      end
      if (clr) mg[id] = 0;
      else if (abort && mg[id] < 255) mg[id]++;
      e.gc = 8'(mg[id]);
      ms[id] = {ms[id][2:0], t};
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
   endtask

   task automatic step();
      model_edge(0, torcvr, filt_en, clr_v);
      model_edge(1, torcvr_f, filt_en, clr_v);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      q0.delete(); q1.delete();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({rcvr_out, rise_pls, fall_pls} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_state: got out/rise/fall=%b%b%b, expected 000", rcvr_out, rise_pls, fall_pls);
      end
      n_checks++;
      if ({rcvr_out_f, rise_pls_f, fall_pls_f} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_state_f: got out/rise/fall=%b%b%b, expected 000", rcvr_out_f, rise_pls_f, fall_pls_f);
      end
`ifdef BW_IO_RCVR_GLITCH_CNT_EN
      n_checks++;
      if (glitch_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_glitch_cnt: got %0d, expected 0", glitch_cnt);
      end
`endif
      rst_l = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         step();
         e = q0.pop_front();
         n_checks++;
         if ({rcvr_out, rise_pls, fall_pls} !== {e.out, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL reset_exit edge %0d: got %b%b%b, expected %b%b%b", k, rcvr_out, rise_pls, fall_pls, e.out, e.rise, e.fall);
         end
      end
   endtask

   task automatic test_rise();
      int first = -1;
      q0.delete(); q1.delete();
      torcvr = 1'b1;
      for (int k = 0; k < 10; k++) begin
         exp_t e;
         step();
         e = q0.pop_front();
         n_checks++;
         if ({rcvr_out, rise_pls, fall_pls} !== {e.out, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL rise_seq edge %0d: got %b%b%b, expected %b%b%b", k, rcvr_out, rise_pls, fall_pls, e.out, e.rise, e.fall);
         end
         if (rcvr_out === 1'b1 && first < 0) first = k;
         if (k == 6) begin
            n_checks++;
            if ({rcvr_out, rise_pls} !== 2'b11) begin
               n_fail++;
               $display("FAIL rise_edge6: got out=%b rise=%b, expected 1 1", rcvr_out, rise_pls);
            end
         end
         if (k == 7) begin
            n_checks++;
            if (rise_pls !== 1'b0) begin
               n_fail++;
               $display("FAIL rise_edge7: got rise=%b, expected 0", rise_pls);
            end
         end
      end
      n_checks++;
      if (first != 6) begin
         n_fail++;
         $display("FAIL rise_latency: got edge %0d, expected 6", first);
      end
      torcvr = 1'b0;
      for (int k = 0; k < 10; k++) begin
         exp_t e;
         step();
         e = q0.pop_front();
         n_checks++;
         if ({rcvr_out, rise_pls, fall_pls} !== {e.out, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL fall_seq edge %0d: got %b%b%b, expected %b%b%b", k, rcvr_out, rise_pls, fall_pls, e.out, e.rise, e.fall);
         end
      end
   endtask

   task automatic test_glitch();
      int activity = 0;
      q0.delete(); q1.delete();
      for (int k = 0; k < 13; k++) begin
         exp_t e;
         torcvr = (k < 3);
         step();
         e = q0.pop_front();
         n_checks++;
         if ({rcvr_out, rise_pls, fall_pls} !== {e.out, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL glitch_seq edge %0d: got %b%b%b, expected %b%b%b", k, rcvr_out, rise_pls, fall_pls, e.out, e.rise, e.fall);
         end
         if (rcvr_out | rise_pls | fall_pls) activity++;
      end
      n_checks++;
      if (activity != 0) begin
         n_fail++;
         $display("FAIL glitch_reject: got %0d active cycles, expected 0", activity);
      end
`ifdef BW_IO_RCVR_GLITCH_CNT_EN
      n_checks++;
      if (glitch_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL glitch_cnt_one: got %0d, expected 1", glitch_cnt);
      end
`endif
   endtask

   task automatic test_bypass();
      logic hist [24];
      logic prev;
      int   trans = 0;
      int   pulses = 0;
      q0.delete(); q1.delete();
      filt_en = 1'b0;
      prev = rcvr_out;
      for (int k = 0; k < 24; k++) begin
         exp_t e;
         if (k % 2 == 0) torcvr = ~torcvr;
         hist[k] = torcvr;
         step();
         e = q0.pop_front();
         n_checks++;
         if ({rcvr_out, rise_pls, fall_pls} !== {e.out, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL bypass_seq edge %0d: got %b%b%b, expected %b%b%b", k, rcvr_out, rise_pls, fall_pls, e.out, e.rise, e.fall);
         end
         if (k >= 3) begin
            n_checks++;
            if (rcvr_out !== hist[k-3]) begin
               n_fail++;
               $display("FAIL bypass_latency edge %0d: got %b, expected %b", k, rcvr_out, hist[k-3]);
            end
         end
         if (rcvr_out !== prev) trans++;
         pulses += int'(rise_pls) + int'(fall_pls);
         prev = rcvr_out;
      end
      n_checks++;
      if (pulses != trans || trans == 0) begin
         n_fail++;
         $display("FAIL bypass_pulses: got %0d pulses for %0d transitions", pulses, trans);
      end
      torcvr = 1'b0;
      for (int k = 0; k < 12; k++) begin
         exp_t e;
         if (k == 4) filt_en = 1'b1;
         step();
         e = q0.pop_front();
         n_checks++;
         if ({rcvr_out, rise_pls, fall_pls} !== {e.out, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL bypass_exit edge %0d: got %b%b%b, expected %b%b%b", k, rcvr_out, rise_pls, fall_pls, e.out, e.rise, e.fall);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic found = 1'b0;
      int   falls = 0;
      q0.delete(); q1.delete();
      torcvr = 1'b1;
      for (int k = 0; k < 10; k++) begin
         exp_t e;
         step();
         e = q0.pop_front();
         n_checks++;
         if ({rcvr_out, rise_pls, fall_pls} !== {e.out, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL rstmid_accept edge %0d: got %b%b%b, expected %b%b%b", k, rcvr_out, rise_pls, fall_pls, e.out, e.rise, e.fall);
         end
      end
      torcvr = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
         exp_t e;
         step();
         e = q0.pop_front();
         n_checks++;
         if ({rcvr_out, rise_pls, fall_pls} !== {e.out, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL rstmid_pend edge %0d: got %b%b%b, expected %b%b%b", k, rcvr_out, rise_pls, fall_pls, e.out, e.rise, e.fall);
         end
         if (ml[0] && mr[0] > 0) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL rstmid_reach_pend: got no HI_PEND within 6 edges, expected one");
      end
      rst_l = 1'b0;
      #1;
      n_checks++;
      if ({rcvr_out, rise_pls, fall_pls} !== 3'b000) begin
         n_fail++;
         $display("FAIL rstmid_clear: got %b%b%b, expected 000", rcvr_out, rise_pls, fall_pls);
      end
      model_reset();
      q0.delete(); q1.delete();
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_t e;
         step();
         e = q0.pop_front();
         n_checks++;
         if ({rcvr_out, rise_pls, fall_pls} !== {e.out, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL rstmid_release edge %0d: got %b%b%b, expected %b%b%b", k, rcvr_out, rise_pls, fall_pls, e.out, e.rise, e.fall);
         end
         falls += int'(fall_pls);
      end
      n_checks++;
      if (falls != 0) begin
         n_fail++;
         $display("FAIL rstmid_no_fall: got %0d fall pulses, expected 0", falls);
      end
   endtask

   task automatic test_fast();
      int highs = 0;
      int first = -1;
      q0.delete(); q1.delete();
      for (int k = 0; k < 9; k++) begin
         exp_t e;
         torcvr_f = (k == 0);
         step();
         e = q1.pop_front();
         n_checks++;
         if ({rcvr_out_f, rise_pls_f, fall_pls_f} !== {e.out, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL fast_seq edge %0d: got %b%b%b, expected %b%b%b", k, rcvr_out_f, rise_pls_f, fall_pls_f, e.out, e.rise, e.fall);
         end
         if (rcvr_out_f === 1'b1) begin
            highs++;
            if (first < 0) first = k;
         end
      end
      n_checks++;
      if (highs != 1 || first != 4) begin
         n_fail++;
         $display("FAIL fast_pulse: got %0d high cycles from edge %0d, expected 1 from edge 4", highs, first);
      end
   endtask

`ifdef BW_IO_RCVR_GLITCH_CNT_EN
   task automatic test_glitch_sat();
      logic cleared = 1'b0;
      q0.delete(); q1.delete();
      for (int g = 0; g < 300; g++) begin
         for (int k = 0; k < 6; k++) begin
            exp_t e;
            torcvr = (k < 3);
            step();
            e = q0.pop_front();
            n_checks++;
            if ({rcvr_out, rise_pls, fall_pls, glitch_cnt} !== {e.out, e.rise, e.fall, e.gc}) begin
               n_fail++;
               $display("FAIL sat_seq glitch %0d edge %0d: got %b%b%b cnt=%0d, expected %b%b%b cnt=%0d",
                        g, k, rcvr_out, rise_pls, fall_pls, glitch_cnt, e.out, e.rise, e.fall, e.gc);
            end
         end
      end
      n_checks++;
      if (glitch_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL glitch_sat: got %0d, expected 255", glitch_cnt);
      end
      torcvr = 1'b1;
      for (int k = 0; k < 9 && !cleared; k++) begin
         exp_t e;
         if (k == 3) torcvr = 1'b0;
         clr_v = (ms[0][1] == 1'b0) && (mr[0] > 0) && filt_en;
         step();
         if (clr_v) cleared = 1'b1;
         clr_v = 1'b0;
         e = q0.pop_front();
         n_checks++;
         if (glitch_cnt !== e.gc) begin
            n_fail++;
            $display("FAIL clr_seq edge %0d: got cnt=%0d, expected %0d", k, glitch_cnt, e.gc);
         end
      end
      n_checks++;
      if (!cleared || glitch_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL glitch_clr_wins: got cnt=%0d (clear applied=%b), expected 0", glitch_cnt, cleared);
      end
   endtask
`endif

   initial begin
      rst_l    = 1'b0;
      torcvr   = 1'b0;
      torcvr_f = 1'b0;
      filt_en  = 1'b1;
      clr_v    = 1'b0;
      model_reset();
      test_reset();
      test_rise();
      test_glitch();
      test_bypass();
      test_reset_mid();
      test_fast();
`ifdef BW_IO_RCVR_GLITCH_CNT_EN
      test_glitch_sat();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
